traffic_phase_timer: RTL

Upstream timing stage for the intersection controller. It owns the phase durations of the six-phase traffic/pedestrian cycle and emits the one-cycle `change` pulse that advances the light FSM. It also produces the per-phase countdown in binary and in BCD for the pedestrian hex displays. It latches pedestrian push-button requests and uses them to shorten the opposing green phase.

---
 rtl/traffic_phase_timer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/traffic_phase_timer.sv
// Phase timer for the six-phase traffic/pedestrian cycle: prescaled one-second
// countdown, change pulse, BCD display value and pedestrian request latching.
module traffic_phase_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int GREEN_S  = 10,
    parameter int FLASH_S  = 15,
    parameter int YELLOW_S = 3,
    parameter int SHORT_S  = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       run,
    input  logic       ped_req1,
    input  logic       ped_req2,
    output logic       change,
    output logic [2:0] phase,
    output logic [6:0] remaining,
    output logic [7:0] bcd_count,
    output logic       req_pending1,
    output logic       req_pending2
);

    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [6:0]      GREEN_V   = 7'(GREEN_S);
    localparam logic [6:0]      FLASH_V   = 7'(FLASH_S);
    localparam logic [6:0]      YELLOW_V  = 7'(YELLOW_S);
    localparam logic [6:0]      SHORT_V   = 7'(SHORT_S);

    // Phases 0..2 keep T1 red (T2 runs, P2 walks); 3..5 are the mirror image.
    typedef enum logic [2:0] {
        PH_T2_GREEN  = 3'd0,
        PH_T2_FLASH  = 3'd1,
        PH_T2_YELLOW = 3'd2,
        PH_T1_GREEN  = 3'd3,
        PH_T1_FLASH  = 3'd4,
        PH_T1_YELLOW = 3'd5
    } phase_e;

    function automatic logic [6:0] phase_duration(input phase_e p);
        logic [6:0] d;
        case (p)
            PH_T2_GREEN, PH_T1_GREEN:   d = GREEN_V;
            PH_T2_FLASH, PH_T1_FLASH:   d = FLASH_V;
            PH_T2_YELLOW, PH_T1_YELLOW: d = YELLOW_V;
            default:                    d = GREEN_V;
        endcase
        return d;
    endfunction

    function automatic phase_e phase_after(input phase_e p);
        phase_e n;
        case (p)
            PH_T2_GREEN:  n = PH_T2_FLASH;
            PH_T2_FLASH:  n = PH_T2_YELLOW;
            PH_T2_YELLOW: n = PH_T1_GREEN;
            PH_T1_GREEN:  n = PH_T1_FLASH;
            PH_T1_FLASH:  n = PH_T1_YELLOW;
            PH_T1_YELLOW: n = PH_T2_GREEN;
            default:      n = PH_T2_GREEN;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens_v;
        logic [3:0] units_v;
        tens_v  = 4'(v / 7'd10);
        units_v = 4'(v % 7'd10);
        return {tens_v, units_v};
    endfunction

    phase_e         phase_r, phase_nx_s;
    logic [6:0]     rem_r, rem_nx_s;
    logic [7:0]     bcd_r, bcd_nx_s;
    logic           change_r, change_nx_s;
    logic [PW-1:0]  presc_r, presc_nx_s;
    logic           pend1_r, pend1_nx_s;
    logic           pend2_r, pend2_nx_s;
    logic [1:0]     sync1_r, sync2_r, prev_r;
    logic [1:0]     edge_s;
    logic           tick_s, advance_s, trunc_s;

    // Two-flop synchroniser and edge-history flops for both buttons.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
            prev_r  <= 2'b00;
        end else begin
            sync1_r <= {ped_req2, ped_req1};
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign edge_s = sync2_r & ~prev_r;

    // Next-state logic for prescaler, countdown, phase and request latches.
    always_comb begin
        presc_nx_s  = presc_r;
        rem_nx_s    = rem_r;
        phase_nx_s  = phase_r;
        change_nx_s = 1'b0;
        pend1_nx_s  = pend1_r;
        pend2_nx_s  = pend2_r;
        tick_s      = 1'b0;
        advance_s   = 1'b0;
        trunc_s     = ((phase_r == PH_T2_GREEN) && pend1_r) ||
                      ((phase_r == PH_T1_GREEN) && pend2_r);

        if (run) begin
            tick_s = (presc_r == PRESC_MAX);
            if (tick_s) begin
                presc_nx_s = {PW{1'b0}};
            end else begin
                presc_nx_s = presc_r + PW'(1);
            end
            // Truncation outranks the tick decrement but leaves the prescaler alone.
            if (tick_s && (rem_r == 7'd1)) begin
                advance_s   = 1'b1;
                phase_nx_s  = phase_after(phase_r);
                rem_nx_s    = phase_duration(phase_nx_s);
                change_nx_s = 1'b1;
            end else if (trunc_s && (rem_r > SHORT_V)) begin
                rem_nx_s = SHORT_V;
            end else if (tick_s) begin
                rem_nx_s = rem_r - 7'd1;
            end else begin
                rem_nx_s = rem_r;
            end
        end else begin
            presc_nx_s = presc_r;
            rem_nx_s   = rem_r;
        end

        if (advance_s && (phase_nx_s == PH_T1_GREEN)) begin
            pend1_nx_s = 1'b0;
        end else if (edge_s[0]) begin
            pend1_nx_s = 1'b1;
        end else begin
            pend1_nx_s = pend1_r;
        end

        if (advance_s && (phase_nx_s == PH_T2_GREEN)) begin
            pend2_nx_s = 1'b0;
        end else if (edge_s[1]) begin
            pend2_nx_s = 1'b1;
        end else begin
            pend2_nx_s = pend2_r;
        end

        bcd_nx_s = to_bcd(rem_nx_s);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            phase_r  <= PH_T2_GREEN;
            rem_r    <= GREEN_V;
            bcd_r    <= to_bcd(GREEN_V);
            change_r <= 1'b0;
            presc_r  <= {PW{1'b0}};
            pend1_r  <= 1'b0;
            pend2_r  <= 1'b0;
        end else begin
            phase_r  <= phase_nx_s;
            rem_r    <= rem_nx_s;
            bcd_r    <= bcd_nx_s;
            change_r <= change_nx_s;
            presc_r  <= presc_nx_s;
            pend1_r  <= pend1_nx_s;
            pend2_r  <= pend2_nx_s;
        end
    end

    assign change       = change_r;
    assign phase        = phase_r;
    assign remaining    = rem_r;
    assign bcd_count    = bcd_r;
    assign req_pending1 = pend1_r;
    assign req_pending2 = pend2_r;

endmodule
